// File: rtl/battle_pkg.sv
// Shared types for the battle engine: FSM states, player moves, PS/2 scancodes
// and the LFSR step function.
package battle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_TURN,
    P_RESOLVE,
    E_WAIT,
    E_RESOLVE,
    WIN,
    LOSE
  } state_t;

  typedef enum logic [1:0] {
    LIGHT,
    HEAVY,
    HEAL
  } move_t;

  typedef struct packed {
    logic  hit;
    move_t mv;
  } key_dec_t;

  localparam logic [7:0]  KEY_LIGHT = 8'h1C;
  localparam logic [7:0]  KEY_HEAVY = 8'h1B;
  localparam logic [7:0]  KEY_HEAL  = 8'h23;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t d;
    d.hit = 1'b1;
    d.mv  = LIGHT;
    case (code)
      KEY_LIGHT: d.mv = LIGHT;
      KEY_HEAVY: d.mv = HEAVY;
      KEY_HEAL:  d.mv = HEAL;
      default:   d.hit = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/battle_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every clock, shared with overworld AI.
module battle_lfsr
  import battle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_b,
  input  logic        rst_b,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/battle_engine.sv
// Turn-based battle FSM: PS/2 player moves, LFSR-driven enemy strikes, HUD outputs.
// Optional critical hits are compiled in with the BATTLE_CRIT_EN macro.
module battle_engine
  import battle_pkg::*;
#(
  parameter int          HP_P_W      = 7,
  parameter int          HP_E_W      = 8,
  parameter int          ATK_W       = 3,
  parameter int          P_HP_MAX    = 100,
  parameter int          E_HP_MAX    = 50,
  parameter int          BOSS_HP_MAX = 200,
  parameter int          LIGHT_DMG   = 3,
  parameter int          HEAVY_DMG   = 7,
  parameter int          HEAL_AMT    = 10,
  parameter int          COOLDOWN    = 2,
  parameter int          BOSS_BONUS  = 2,
  parameter int          ENEMY_DELAY = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              clk_b,
  input  logic              rst_b,
  input  logic              col_e,
  input  logic              boss,
  input  logic [7:0]        key_in,
  input  logic              key_valid,
  output logic [HP_P_W-1:0] HP_player,
  output logic [HP_E_W-1:0] HP_enemy,
  output logic [ATK_W-1:0]  p_attack,
  output logic [ATK_W-1:0]  e_attack,
  output logic              battle_active,
  output logic              win,
  output logic              lose,
  output logic              heavy_ready
`ifdef BATTLE_CRIT_EN
  ,
  output logic              crit
`endif
);

  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int DLY_W = (ENEMY_DELAY > 1) ? $clog2(ENEMY_DELAY) : 1;
  localparam int ED_W  = ATK_W + 2;
  localparam int PS_W  = (HP_P_W > ED_W) ? HP_P_W : ED_W;
  localparam int PD_W  = HP_E_W + 2;

  localparam logic [HP_P_W-1:0] P_FULL   = HP_P_W'(P_HP_MAX);
  localparam logic [HP_P_W:0]   P_CAP    = (HP_P_W + 1)'(P_HP_MAX);
  localparam logic [HP_P_W:0]   HEAL_X   = (HP_P_W + 1)'(HEAL_AMT);
  localparam logic [HP_E_W-1:0] E_START  = HP_E_W'(E_HP_MAX);
  localparam logic [HP_E_W-1:0] B_START  = HP_E_W'(BOSS_HP_MAX);
  localparam logic [PD_W-1:0]   LIGHT_X  = PD_W'(LIGHT_DMG);
  localparam logic [PD_W-1:0]   HEAVY_X  = PD_W'(HEAVY_DMG);
  localparam logic [ED_W-1:0]   BONUS_X  = ED_W'(BOSS_BONUS);
  localparam logic [CD_W-1:0]   CD_LOAD  = CD_W'(COOLDOWN);
  localparam logic [DLY_W-1:0]  DLY_LOAD = DLY_W'(ENEMY_DELAY - 1);

  state_t              state_q, state_d;
  move_t               move_q, move_d;
  logic                col_prev_q;
  logic                boss_q, boss_d;
  logic [HP_P_W-1:0]   hp_p_q, hp_p_d;
  logic [HP_E_W-1:0]   hp_e_q, hp_e_d;
  logic [ATK_W-1:0]    p_atk_q, p_atk_d;
  logic [ATK_W-1:0]    e_atk_q, e_atk_d;
  logic [CD_W-1:0]     cd_q, cd_d;
  logic [DLY_W-1:0]    dly_q, dly_d;

  logic [15:0]         lfsr_w;
  logic                unused_lfsr_bits;
  logic                col_rise;
  key_dec_t            key_dec;
  logic                key_take;
  logic [PD_W-1:0]     p_dmg;
  logic [ATK_W-1:0]    p_atk_val;
  logic [HP_E_W-1:0]   hp_e_hit;
  logic [HP_E_W-1:0]   hp_e_res;
  logic [HP_P_W:0]     heal_sum;
  logic [HP_P_W-1:0]   hp_heal;
  logic [ED_W-1:0]     e_dmg;
  logic [PS_W-1:0]     e_dmg_ext;
  logic [HP_P_W-1:0]   hp_p_hit;

  battle_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_b (clk_b),
    .rst_b (rst_b),
    .out   (lfsr_w)
  );

  assign unused_lfsr_bits = ^lfsr_w[15:ATK_W];

  assign col_rise = col_e & ~col_prev_q;
  assign key_dec  = decode_key(key_in);
  // A heavy attack still on cooldown is treated exactly like an unknown key.
  assign key_take = (state_q == P_TURN) && key_valid && key_dec.hit &&
                    ((key_dec.mv != HEAVY) || (cd_q == '0));

`ifdef BATTLE_CRIT_EN
  logic crit_hit;
  assign crit_hit = (state_q == P_RESOLVE) && (move_q != HEAL) && (lfsr_w[7:5] == 3'b111);
`endif

  always_comb begin
    p_dmg     = (move_q == HEAVY) ? HEAVY_X : LIGHT_X;
    p_atk_val = p_dmg[ATK_W-1:0];
`ifdef BATTLE_CRIT_EN
    if (crit_hit) begin
      p_dmg     = p_dmg << 1;
      p_atk_val = (|(p_dmg >> ATK_W)) ? '1 : p_dmg[ATK_W-1:0];
    end
`endif
  end

  assign hp_e_hit = (p_dmg >= PD_W'(hp_e_q)) ? '0 : hp_e_q - p_dmg[HP_E_W-1:0];
  assign hp_e_res = (move_q == HEAL) ? hp_e_q : hp_e_hit;

  assign heal_sum = {1'b0, hp_p_q} + HEAL_X;
  assign hp_heal  = (heal_sum > P_CAP) ? P_FULL : heal_sum[HP_P_W-1:0];

  // Enemy damage keeps two headroom bits so the boss bonus never wraps.
  assign e_dmg     = {2'b00, lfsr_w[ATK_W-1:0]} + (boss_q ? BONUS_X : ED_W'(0));
  assign e_dmg_ext = PS_W'(e_dmg);
  assign hp_p_hit  = (e_dmg_ext >= PS_W'(hp_p_q)) ? '0 : hp_p_q - e_dmg_ext[HP_P_W-1:0];

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      state_q    <= IDLE;
      move_q     <= LIGHT;
      col_prev_q <= 1'b0;
      boss_q     <= 1'b0;
      hp_p_q     <= P_FULL;
      hp_e_q     <= '0;
      p_atk_q    <= '0;
      e_atk_q    <= '0;
      cd_q       <= '0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      move_q     <= move_d;
      col_prev_q <= col_e;
      boss_q     <= boss_d;
      hp_p_q     <= hp_p_d;
      hp_e_q     <= hp_e_d;
      p_atk_q    <= p_atk_d;
      e_atk_q    <= e_atk_d;
      cd_q       <= cd_d;
      dly_q      <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (col_rise) state_d = P_TURN;
      P_TURN:    if (key_take) state_d = P_RESOLVE;
      P_RESOLVE: state_d = (hp_e_res == '0) ? WIN : E_WAIT;
      E_WAIT:    if (dly_q == '0) state_d = E_RESOLVE;
      E_RESOLVE: state_d = (hp_p_hit == '0) ? LOSE : P_TURN;
      WIN, LOSE: if (!col_e) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    boss_d  = boss_q;
    move_d  = move_q;
    hp_p_d  = hp_p_q;
    hp_e_d  = hp_e_q;
    p_atk_d = p_atk_q;
    e_atk_d = e_atk_q;
    cd_d    = cd_q;
    dly_d   = dly_q;
    case (state_q)
      IDLE: begin
        if (col_rise) begin
          boss_d  = boss;
          hp_e_d  = boss ? B_START : E_START;
          p_atk_d = '0;
          e_atk_d = '0;
        end
      end
      P_TURN: begin
        if (key_take) move_d = key_dec.mv;
      end
      P_RESOLVE: begin
        hp_e_d = hp_e_res;
        if (move_q == HEAL) begin
          hp_p_d  = hp_heal;
          p_atk_d = '0;
        end else begin
          p_atk_d = p_atk_val;
        end
        if (move_q == HEAVY) begin
          cd_d = CD_LOAD;
        end else if (cd_q != '0) begin
          cd_d = cd_q - CD_W'(1);
        end
        dly_d = DLY_LOAD;
      end
      E_WAIT: begin
        if (dly_q != '0) dly_d = dly_q - DLY_W'(1);
      end
      E_RESOLVE: begin
        e_atk_d = e_dmg[ATK_W-1:0];
        hp_p_d  = hp_p_hit;
      end
      LOSE: begin
        if (!col_e) hp_p_d = P_FULL;
      end
      default: ;
    endcase
  end

  always_comb begin
    battle_active = 1'b0;
    win           = 1'b0;
    lose          = 1'b0;
    case (state_q)
      IDLE:    ;
      WIN:     win  = 1'b1;
      LOSE:    lose = 1'b1;
      default: battle_active = 1'b1;
    endcase
`ifdef BATTLE_CRIT_EN
    crit = crit_hit;
`endif
  end

  assign HP_player   = hp_p_q;
  assign HP_enemy    = hp_e_q;
  assign p_attack    = p_atk_q;
  assign e_attack    = e_atk_q;
  assign heavy_ready = (cd_q == '0);

endmodule
